sync_fifo_param: RTL

Single-clock, fully parametrised FIFO. It is the synchronous successor to the dual-clock FIFO, for use where producer and consumer share a clock domain. It adds the following to the existing full/empty/valid/overflow/underflow set:
- fill-level count
- programmable almost_full and almost_empty thresholds
- selectable read mode: registered (standard) or first-word-fall-through (FWFT)

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/fifo_mem.sv | 29 ++
 rtl/sync_fifo_param.sv | 109 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the single-clock parametrised FIFO.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_FIFO_DEPTH   = 16;
  localparam int DEF_ALMOST_FULL  = 12;
  localparam int DEF_ALMOST_EMPTY = 2;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // Pointer width for a given depth: index bits plus one wrap bit.
  function automatic int addr_width(input int depth);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < depth) begin
        w = i + 1;
      end
    end
    return w + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: register array with a synchronous write port and an
// asynchronous read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int data_width = DEF_DATA_WIDTH,
  parameter int fifo_depth = DEF_FIFO_DEPTH,
  parameter int index_bits = addr_width(DEF_FIFO_DEPTH) - 1
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [index_bits-1:0] i_waddr,
  input  logic [data_width-1:0] i_wdata,
  input  logic [index_bits-1:0] i_raddr,
  output logic [data_width-1:0] o_rdata
);

  logic [data_width-1:0] r_mem [fifo_depth];

  // Write port; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with fill count, almost flags and a
// selectable registered or first-word-fall-through read path.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int data_width          = DEF_DATA_WIDTH,
  parameter int fifo_depth          = DEF_FIFO_DEPTH,
  parameter int address_size        = addr_width(DEF_FIFO_DEPTH),
  parameter int almost_full_thresh  = DEF_ALMOST_FULL,
  parameter int almost_empty_thresh = DEF_ALMOST_EMPTY,
  parameter int fwft_mode           = FIFO_STD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [data_width-1:0]   wdata,
  input  logic                    rd_en,
  output logic [data_width-1:0]   rdata,
  output logic                    valid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [address_size-1:0] count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int IDX_W = address_size - 1;
  localparam logic [address_size-1:0] AF_T = address_size'(almost_full_thresh);
  localparam logic [address_size-1:0] AE_T = address_size'(almost_empty_thresh);
  localparam logic [address_size-1:0] ONE  = address_size'(1);

  logic [address_size-1:0] r_wr_ptr, r_rd_ptr, r_count;
  logic [address_size-1:0] w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [data_width-1:0]   r_rdata, w_mem_rdata;
  logic                    r_valid, r_overflow, r_underflow;
  logic                    w_full, w_empty, w_wr_acc, w_rd_acc;

  // Full when only the wrap bits differ, empty when the pointers match.
  assign w_full   = (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]) &&
                    (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]);
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_wr_acc = wr_en && !w_full;
  assign w_rd_acc = rd_en && !w_empty;

  // Next pointer values from the accept decisions.
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    if (w_wr_acc) begin
      w_wr_ptr_nxt = r_wr_ptr + ONE;
    end else begin
      w_wr_ptr_nxt = r_wr_ptr;
    end
    if (w_rd_acc) begin
      w_rd_ptr_nxt = r_rd_ptr + ONE;
    end else begin
      w_rd_ptr_nxt = r_rd_ptr;
    end
  end

  // Pointers, occupancy, registered read path and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= {address_size{1'b0}};
      r_rd_ptr    <= {address_size{1'b0}};
      r_count     <= {address_size{1'b0}};
      r_rdata     <= {data_width{1'b0}};
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_count     <= w_wr_ptr_nxt - w_rd_ptr_nxt;
      r_valid     <= w_rd_acc;
      r_overflow  <= wr_en && w_full;
      r_underflow <= rd_en && w_empty;
      if (w_rd_acc) begin
        r_rdata <= w_mem_rdata;
      end
    end
  end

  fifo_mem #(
    .data_width (data_width),
    .fifo_depth (fifo_depth),
    .index_bits (IDX_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_acc && !rst),
    .i_waddr (r_wr_ptr[IDX_W-1:0]),
    .i_wdata (wdata),
    .i_raddr (r_rd_ptr[IDX_W-1:0]),
    .o_rdata (w_mem_rdata)
  );

  assign rdata        = (fwft_mode == FIFO_FWFT) ? w_mem_rdata : r_rdata;
  assign valid        = (fwft_mode == FIFO_FWFT) ? !w_empty    : r_valid;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= AF_T);
  assign almost_empty = (r_count <= AE_T);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
